// File: rtl/pixel_segment_classifier_if.sv
// Pixel stream / segment result bundle for pixel_segment_classifier.
// Optional Show_BlackCnt member present when SEG_COUNT_EN is defined.
interface pixel_segment_classifier_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             PixelIN;
    logic             PixelIN_valid;
    logic [1:0]       Show_Data;
    logic             Show_Valid;
    logic             Show_Ready;
    logic             Overflow;
`ifdef SEG_COUNT_EN
    logic [CNT_W-1:0] Show_BlackCnt;
`endif

`ifdef SEG_COUNT_EN
    // Pixel source / result consumer side
    modport master (
        output PixelIN, PixelIN_valid, Show_Ready,
        input  Show_Data, Show_Valid, Overflow, Show_BlackCnt
    );
    // Classifier side
    modport slave (
        input  PixelIN, PixelIN_valid, Show_Ready,
        output Show_Data, Show_Valid, Overflow, Show_BlackCnt
    );
`else
    // Pixel source / result consumer side
    modport master (
        output PixelIN, PixelIN_valid, Show_Ready,
        input  Show_Data, Show_Valid, Overflow
    );
    // Classifier side
    modport slave (
        input  PixelIN, PixelIN_valid, Show_Ready,
        output Show_Data, Show_Valid, Overflow
    );
`endif
endinterface

// File: rtl/pixel_segment_classifier.sv
// Splits a serial binary pixel stream into WIN_LEN-pixel segments and
// classifies each as white / black / white-to-black / black-to-white.
// Results sit in a one-entry valid/ready register; a result that cannot be
// stored is dropped and flagged on the sticky Overflow output.
// Optional: define SEG_COUNT_EN to add Show_BlackCnt (black pixel count).
module pixel_segment_classifier #(
    parameter int unsigned WIN_LEN  = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned EDGE_TOL = 1
) (
    input  logic                          PixelSeg_clk,
    input  logic                          PixelSeg_rst_n,
    pixel_segment_classifier_if.slave     seg
);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] HALF_IDX  = CNT_W'(WIN_LEN / 2);
    localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] SOLID_CNT = CNT_W'(WIN_LEN - EDGE_TOL);

    localparam logic [1:0] CODE_WHITE = 2'b00;
    localparam logic [1:0] CODE_W2B   = 2'b01;
    localparam logic [1:0] CODE_B2W   = 2'b10;
    localparam logic [1:0] CODE_BLACK = 2'b11;

    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] b_first_q, b_first_d;
    logic [CNT_W-1:0] b_second_q, b_second_d;
    logic [1:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
`ifdef SEG_COUNT_EN
    logic [CNT_W-1:0] blk_q, blk_d;
`endif

    logic             pix_blk_c;
    logic             first_half_c;
    logic             close_c;
    logic             load_ok_c;
    logic [CNT_W-1:0] b_first_n_c;
    logic [CNT_W-1:0] b_second_n_c;
    logic [CNT_W-1:0] b_tot_c;
    logic [CNT_W-1:0] w_tot_c;
    logic [1:0]       code_c;

    // Count update including the current pixel, and segment classification
    always_comb begin
        pix_blk_c    = seg.PixelIN_valid && seg.PixelIN;
        first_half_c = (idx_q < HALF_IDX);
        close_c      = seg.PixelIN_valid && (idx_q == LAST_IDX);
        b_first_n_c  = b_first_q  + CNT_W'(pix_blk_c &&  first_half_c);
        b_second_n_c = b_second_q + CNT_W'(pix_blk_c && !first_half_c);
        b_tot_c      = b_first_n_c + b_second_n_c;
        w_tot_c      = WIN_CNT - b_tot_c;

        code_c = CODE_WHITE;
        if (b_tot_c >= SOLID_CNT) begin
            code_c = CODE_BLACK;
        end else if (w_tot_c >= SOLID_CNT) begin
            code_c = CODE_WHITE;
        end else if (b_second_n_c > b_first_n_c) begin
            code_c = CODE_W2B;
        end else if (b_first_n_c > b_second_n_c) begin
            code_c = CODE_B2W;
        end else if (b_tot_c > w_tot_c) begin
            code_c = CODE_BLACK;
        end
    end

    // Next-state for the accumulator and the one-entry output register
    always_comb begin
        idx_d      = idx_q;
        b_first_d  = b_first_q;
        b_second_d = b_second_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
`ifdef SEG_COUNT_EN
        blk_d      = blk_q;
`endif
        load_ok_c  = !valid_q || seg.Show_Ready;

        if (seg.PixelIN_valid) begin
            if (close_c) begin
                idx_d      = '0;
                b_first_d  = '0;
                b_second_d = '0;
            end else begin
                idx_d      = idx_q + CNT_W'(1);
                b_first_d  = b_first_n_c;
                b_second_d = b_second_n_c;
            end
        end

        if (close_c && load_ok_c) begin
            data_d  = code_c;
            valid_d = 1'b1;
`ifdef SEG_COUNT_EN
            blk_d   = b_tot_c;
`endif
        end else if (close_c) begin
            // Held result not consumed: drop the new one
            ovf_d = 1'b1;
        end else if (valid_q && seg.Show_Ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge PixelSeg_clk or negedge PixelSeg_rst_n) begin
        if (!PixelSeg_rst_n) begin
            idx_q      <= '0;
            b_first_q  <= '0;
            b_second_q <= '0;
            data_q     <= CODE_WHITE;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef SEG_COUNT_EN
            blk_q      <= '0;
`endif
        end else begin
            idx_q      <= idx_d;
            b_first_q  <= b_first_d;
            b_second_q <= b_second_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
`ifdef SEG_COUNT_EN
            blk_q      <= blk_d;
`endif
        end
    end

    assign seg.Show_Data  = data_q;
    assign seg.Show_Valid = valid_q;
    assign seg.Overflow   = ovf_q;
`ifdef SEG_COUNT_EN
    assign seg.Show_BlackCnt = blk_q;
`endif

endmodule
